conv_window_gen: RTL

//  Multi-channel sliding-window generator that replaces the fixed stride-1, unpadded conv input buffer.

---
 rtl/conv_window_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Multi-channel KxK sliding-window generator with internal zero padding and stride.
// Pixels arrive in raster order; windows leave on a valid/ready handshake in c*K^2 + r*K + k order.
module conv_window_gen #(
    parameter int input_channels = 6,
    parameter int img_width      = 28,
    parameter int img_height     = 28,
    parameter int kernel_dim     = 5,
    parameter int stride         = 1,
    parameter int padding        = 0,
    parameter int datatype_size  = 8,
    localparam int PW    = img_width + 2 * padding,
    localparam int PH    = img_height + 2 * padding,
    localparam int OUT_W = (PW - kernel_dim) / stride + 1,
    localparam int OUT_H = (PH - kernel_dim) / stride + 1,
    localparam int NWIN  = input_channels * kernel_dim * kernel_dim,
    localparam int ROW_W = $clog2(OUT_H + 1),
    localparam int COL_W = $clog2(OUT_W + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_valid,
    input  logic [input_channels-1:0][datatype_size-1:0] i_data,
    output logic                                        o_ready,
    output logic                                        o_win_valid,
    input  logic                                        i_win_ready,
    output logic [NWIN-1:0][datatype_size-1:0]          o_win_data,
    output logic [ROW_W-1:0]                            o_win_row,
    output logic [COL_W-1:0]                            o_win_col,
    output logic                                        o_frame_done
);
    localparam int PR_W = $clog2(PH);
    localparam int PC_W = $clog2(PW);
    localparam int SL_W = (kernel_dim > 1) ? $clog2(kernel_dim) : 1;

    typedef logic [input_channels-1:0][datatype_size-1:0] pix_t;

    // Rows live in slot pr % K, so the K most recent padded rows are always resident.
    pix_t lb [kernel_dim][PW];

    logic [PR_W-1:0] pr;
    logic [PC_W-1:0] pc;
    int              pri, pci;
    logic            interior, en, adv, trig, last;
    logic [SL_W-1:0] wslot;
    pix_t            pix;
    logic [NWIN-1:0][datatype_size-1:0] win;

    assign pri      = int'(pr);
    assign pci      = int'(pc);
    assign interior = (pri >= padding) && (pri < PH - padding) &&
                      (pci >= padding) && (pci < PW - padding);
    assign en       = !o_win_valid || i_win_ready;
    assign o_ready  = !rst && interior && en;
    assign adv      = !rst && en && (!interior || i_valid);
    assign pix      = interior ? i_data : '0;
    assign wslot    = SL_W'(pri % kernel_dim);
    assign last     = (pri == PH - 1) && (pci == PW - 1);
    assign trig     = adv && (pri >= kernel_dim - 1) && (pci >= kernel_dim - 1) &&
                      ((pri - kernel_dim + 1) % stride == 0) &&
                      ((pci - kernel_dim + 1) % stride == 0);

    // Window gather; the bottom-right element bypasses the buffer since it is written this cycle.
    for (genvar c = 0; c < input_channels; c++) begin : g_ch
        for (genvar r = 0; r < kernel_dim; r++) begin : g_row
            for (genvar k = 0; k < kernel_dim; k++) begin : g_col
                localparam int E = c * kernel_dim * kernel_dim + r * kernel_dim + k;
                if (r == kernel_dim - 1 && k == kernel_dim - 1) begin : g_new
                    assign win[E] = pix[c];
                end else begin : g_old
                    logic [SL_W-1:0] rs;
                    logic [PC_W-1:0] cs;
                    assign rs     = SL_W'((pri + 1 + r) % kernel_dim);
                    assign cs     = (pci >= kernel_dim - 1 - k) ?
                                    PC_W'(pci - (kernel_dim - 1 - k)) : '0;
                    assign win[E] = lb[rs][cs][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) lb[wslot][pc] <= pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr           <= '0;
            pc           <= '0;
            o_win_valid  <= 1'b0;
            o_win_data   <= '0;
            o_win_row    <= '0;
            o_win_col    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= adv && last;
            if (adv) begin
                if (pci == PW - 1) begin
                    pc <= '0;
                    pr <= (pri == PH - 1) ? '0 : PR_W'(pri + 1);
                end else begin
                    pc <= PC_W'(pci + 1);
                end
            end
            if (trig) begin
                o_win_valid <= 1'b1;
                o_win_data  <= win;
                o_win_row   <= ROW_W'((pri - kernel_dim + 1) / stride);
                o_win_col   <= COL_W'((pci - kernel_dim + 1) / stride);
            end else if (i_win_ready) begin
                o_win_valid <= 1'b0;
            end
        end
    end
endmodule
